prog_mem_loadable: RTL

- Parametrised successor to the fixed combinational program ROM.
- Synchronous-read program memory with configurable word width and depth, a fetch port with a valid flag, and an auto-incrementing loader FSM so programs can be streamed in at run time.
- Sits between the program counter/fetch stage and an external loader (testbench or boot UART).
- Unwritten locations read as zero, preserving the old ROM's "all others zero" contract.

---
 rtl/prog_mem_pkg.sv | 14 +
 rtl/prog_mem_array.sv | 60 ++++++
 rtl/prog_mem_loadable.sv | 120 ++++++++++++
 3 files changed

// File: rtl/prog_mem_pkg.sv
// Shared types and default widths for the loadable program memory.
// Included by both the storage array and the loader/fetch top level.
package prog_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

    localparam int DATA_W_DEF = 27;
    localparam int ADDR_W_DEF = 8;

endpackage

// File: rtl/prog_mem_array.sv
// Single-port program RAM with a registered read port and a per-word
// written flag; only the flags clear on reset so the array maps onto block RAM.
module prog_mem_array #(
    parameter int DATA_W = 27,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [DATA_W-1:0] i_wrData,
    input  logic              i_rdEn,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [DATA_W-1:0] o_rdData
);

    localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_written;
    logic [DATA_W-1:0] r_rdData;

    logic [IDX_W-1:0]  w_wrIdx;
    logic [IDX_W-1:0]  w_rdIdx;
    logic              w_wrOk;
    logic              w_rdOk;

    assign w_wrIdx = i_wrAddr[IDX_W-1:0];
    assign w_rdIdx = i_rdAddr[IDX_W-1:0];
    assign w_wrOk  = i_wrEn && ({1'b0, i_wrAddr} < DEPTH_X);
    assign w_rdOk  = {1'b0, i_rdAddr} < DEPTH_X;

    always_ff @(posedge Clk) begin
        if (w_wrOk) begin
            r_mem[w_wrIdx] <= i_wrData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_written <= '0;
        end else if (w_wrOk) begin
            r_written[w_wrIdx] <= 1'b1;
        end
    end

    // Unwritten or out-of-range words read as zero; the output holds between reads.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rdData <= '0;
        end else if (i_rdEn) begin
            r_rdData <= (w_rdOk && r_written[w_rdIdx]) ? r_mem[w_rdIdx] : '0;
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/prog_mem_loadable.sv
// Program memory with a one-cycle fetch port and an auto-incrementing
// loader FSM that streams words in at run time; fetches are gated while loading.
module prog_mem_loadable
    import prog_mem_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = 256
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Fetch_Req,
    input  logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Data_Valid,
    output logic              Addr_Err,
    output logic              Busy,
    input  logic              Load_Start,
    input  logic [ADDR_W-1:0] Load_Base,
    input  logic              Load_Valid,
    input  logic [DATA_W-1:0] Load_Data,
    input  logic              Load_Last,
    output logic              Load_Done,
    output logic              Load_Ovf
);

    // Pointer carries one extra bit so DEPTH == 2**ADDR_W compares cleanly.
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_X  = (ADDR_W + 1)'(DEPTH - 1);

    load_state_t     r_state;
    load_state_t     w_stateNext;
    logic [ADDR_W:0] r_ptr;
    logic [ADDR_W:0] w_ptrNext;
    logic            r_ovf;
    logic            w_ovfNext;
    logic            r_valid;
    logic            r_addrErr;

    logic            w_fetch;
    logic            w_addrOk;
    logic            w_baseOk;
    logic            w_wrEn;

    assign w_fetch  = Fetch_Req && (r_state == IDLE);
    assign w_addrOk = {1'b0, Address} < DEPTH_X;
    assign w_baseOk = {1'b0, Load_Base} < DEPTH_X;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_ovf     <= 1'b0;
            r_valid   <= 1'b0;
            r_addrErr <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_ptr     <= w_ptrNext;
            r_ovf     <= w_ovfNext;
            r_valid   <= w_fetch;
            r_addrErr <= w_fetch && !w_addrOk;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_ptrNext   = r_ptr;
        w_ovfNext   = r_ovf;
        w_wrEn      = 1'b0;
        case (r_state)
            IDLE: begin
                if (Load_Start) begin
                    w_ptrNext   = {1'b0, Load_Base};
                    w_ovfNext   = !w_baseOk;
                    w_stateNext = w_baseOk ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (Load_Valid) begin
                    w_wrEn    = 1'b1;
                    w_ptrNext = r_ptr + 1'b1;
                    if (Load_Last || (r_ptr == LAST_X)) begin
                        w_stateNext = DONE;
                    end
                end
            end
            DONE: begin
                if (Load_Valid) begin
                    w_ovfNext = 1'b1;
                end
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    prog_mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_wrEn   (w_wrEn),
        .i_wrAddr (r_ptr[ADDR_W-1:0]),
        .i_wrData (Load_Data),
        .i_rdEn   (w_fetch),
        .i_rdAddr (Address),
        .o_rdData (Data_Out)
    );

    assign Data_Valid = r_valid;
    assign Addr_Err   = r_addrErr;
    assign Busy       = (r_state != IDLE);
    assign Load_Done  = (r_state == DONE);
    assign Load_Ovf   = r_ovf;

endmodule
